// File: rtl/ippcrc_crc12_frmctl.sv
// Framed CRC-12 generator/checker over 104-bit words.
// Accumulates words SOP..EOP, then holds one result until res_rdy.
module ippcrc_crc12_104b (
  input  logic [11:0]  ci,
  input  logic [103:0] di,
  output logic [11:0]  co
);
  localparam logic [11:0] POLY = 12'h80F;

  logic [11:0] c;

  // di[0] enters the shift register first, di[103] last
  always_comb begin
    c = ci;
    for (int i = 0; i < 104; i++) begin
      if (c[11] ^ di[i])
        c = {c[10:0], 1'b0} ^ POLY;
      else
        c = {c[10:0], 1'b0};
    end
    co = c;
  end
endmodule

module ippcrc_crc12_frmctl #(
  parameter logic [11:0] CRC_INIT   = 12'h000,
  parameter logic [11:0] CRC_XOROUT = 12'h000,
  parameter int          MAX_WORDS  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode_chk,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         in_sop,
  input  logic         in_eop,
  input  logic [103:0] in_dat,
  input  logic [11:0]  in_crc,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [11:0]  res_crc,
  output logic         res_err,
  output logic         res_len_err,
  output logic [7:0]   res_nwrd,
  output logic         ev_nosop,
  output logic         ev_abort
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESULT
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] rem_q;
  logic [7:0]  cnt_q;
  logic        mode_q;

  logic [11:0] ci;
  logic [11:0] crc_o;
  logic [11:0] crc_fin;
  logic [7:0]  cnt_nxt;
  logic        mode_nxt;
  logic        acc;
  logic        load;
  logic        fin;
  logic        nosop_c;
  logic        abort_c;

  assign in_rdy  = (state != RESULT);
  assign res_vld = (state == RESULT);
  assign acc     = in_vld & in_rdy;

  assign ci       = in_sop ? CRC_INIT : rem_q;
  assign crc_fin  = crc_o ^ CRC_XOROUT;
  assign mode_nxt = in_sop ? mode_chk : mode_q;

  always_comb begin
    if (in_sop)
      cnt_nxt = 8'd1;
    else if (cnt_q == 8'hFF)
      cnt_nxt = cnt_q;
    else
      cnt_nxt = cnt_q + 8'd1;
  end

  ippcrc_crc12_104b u_core (
    .ci (ci),
    .di (in_dat),
    .co (crc_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fin       = 1'b0;
    nosop_c   = 1'b0;
    abort_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (in_sop) begin
            load = 1'b1;
            if (in_eop) begin
              fin       = 1'b1;
              state_nxt = RESULT;
            end else begin
              state_nxt = BUSY;
            end
          end else begin
            nosop_c = 1'b1;
          end
        end
      end
      BUSY: begin
        if (acc) begin
          load    = 1'b1;
          abort_c = in_sop;
          if (in_eop) begin
            fin       = 1'b1;
            state_nxt = RESULT;
          end
        end
      end
      RESULT: begin
        if (res_rdy)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= CRC_INIT;
      cnt_q       <= 8'd0;
      mode_q      <= 1'b0;
      res_crc     <= 12'h000;
      res_err     <= 1'b0;
      res_len_err <= 1'b0;
      res_nwrd    <= 8'd0;
      ev_nosop    <= 1'b0;
      ev_abort    <= 1'b0;
    end else begin
      ev_nosop <= nosop_c;
      ev_abort <= abort_c;
      if (load) begin
        rem_q  <= crc_o;
        cnt_q  <= cnt_nxt;
        mode_q <= mode_nxt;
      end
      // result registers only move on the EOP word, so they hold in RESULT
      if (fin) begin
        res_crc     <= crc_fin;
        res_err     <= mode_nxt & (crc_fin != in_crc);
        res_len_err <= (32'(cnt_nxt) > MAX_WORDS);
        res_nwrd    <= cnt_nxt;
      end
    end
  end
endmodule

// File: tb/tb_ippcrc_crc12_frmctl.sv
// Directed bench for ippcrc_crc12_frmctl with a result scoreboard.
// A second instance with MAX_WORDS = 2 shares the stimulus.
module tb_ippcrc_crc12_frmctl;
  logic         clk = 1'b0;
  logic         rst;
  logic         mode_chk;
  logic         in_vld;
  logic         in_sop;
  logic         in_eop;
  logic [103:0] in_dat;
  logic [11:0]  in_crc;
  logic         res_rdy;

  logic         in_rdy, res_vld, res_err, res_len_err;
  logic [11:0]  res_crc;
  logic [7:0]   res_nwrd;
  logic         ev_nosop, ev_abort;

  logic         in_rdy2, res_vld2, res_err2, res_len_err2;
  logic [11:0]  res_crc2;
  logic [7:0]   res_nwrd2;
  logic         ev_nosop2, ev_abort2;

  typedef struct {
    logic [11:0] crc;
    logic        err;
    logic [7:0]  nwrd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic        m_busy;
  logic [11:0] m_rem;
  logic [7:0]  m_cnt;
  logic        m_mode;

  always #5 clk = ~clk;

  ippcrc_crc12_frmctl dut (
    .clk         (clk),
    .rst         (rst),
    .mode_chk    (mode_chk),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_dat      (in_dat),
    .in_crc      (in_crc),
    .res_vld     (res_vld),
    .res_rdy     (res_rdy),
    .res_crc     (res_crc),
    .res_err     (res_err),
    .res_len_err (res_len_err),
    .res_nwrd    (res_nwrd),
    .ev_nosop    (ev_nosop),
    .ev_abort    (ev_abort)
  );

  ippcrc_crc12_frmctl #(.MAX_WORDS(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .mode_chk    (mode_chk),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy2),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_dat      (in_dat),
    .in_crc      (in_crc),
    .res_vld     (res_vld2),
    .res_rdy     (res_rdy),
    .res_crc     (res_crc2),
    .res_err     (res_err2),
    .res_len_err (res_len_err2),
    .res_nwrd    (res_nwrd2),
    .ev_nosop    (ev_nosop2),
    .ev_abort    (ev_abort2)
  );

  // reference: remainder of (ci*x^104 + M(x)*x^12) mod x^12+x^11+x^3+x^2+x+1,
  // with di[0] as the highest-order message coefficient
  function automatic logic [11:0] crc_ref(input logic [11:0] ci,
                                          input logic [103:0] di);
    logic [115:0] p;
    p = '0;
    for (int k = 0; k < 12; k++) p[104+k] = ci[k];
    for (int i = 0; i < 104; i++) p[115-i] = p[115-i] ^ di[i];
    for (int b = 115; b >= 12; b--)
      if (p[b]) p[b-:13] = p[b-:13] ^ 13'h180F;
    return p[11:0];
  endfunction

  function automatic logic [103:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[103:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // drive one word starting at a negedge; returns on the next negedge
  task automatic word(input logic sop, input logic eop, input logic md,
                      input logic [103:0] d, input logic [11:0] c);
    exp_t e;
    in_vld   = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    mode_chk = md;
    in_dat   = d;
    in_crc   = c;
    chk("in_rdy", 32'(in_rdy), 32'd1);
    if (sop) begin
      m_rem  = crc_ref(12'h000, d);
      m_cnt  = 8'd1;
      m_mode = md;
      m_busy = 1'b1;
    end else if (m_busy) begin
      m_rem = crc_ref(m_rem, d);
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    if (eop && m_busy) begin
      e.crc  = m_rem;
      e.err  = m_mode & (m_rem != c);
      e.nwrd = m_cnt;
      sb.push_back(e);
      m_busy = 1'b0;
    end
    @(negedge clk);
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic get_result();
    exp_t e;
    int   n;
    n = 0;
    while (res_vld !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("res_latency", 32'(n), 32'd0);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (res_vld === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_crc", 32'(res_crc), 32'(e.crc));
      chk("res_err", 32'(res_err), 32'(e.err));
      chk("res_nwrd", 32'(res_nwrd), 32'(e.nwrd));
      chk("res_len_err", 32'(res_len_err), 32'(e.nwrd > 8'd16));
      chk("res_vld2", 32'(res_vld2), 32'd1);
      chk("res_crc2", 32'(res_crc2), 32'(e.crc));
      chk("res_nwrd2", 32'(res_nwrd2), 32'(e.nwrd));
      chk("res_len_err2", 32'(res_len_err2), 32'(e.nwrd > 8'd2));
    end
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    chk("vld_drop", 32'(res_vld), 32'd0);
    chk("rdy_back", 32'(in_rdy), 32'd1);
  endtask

  initial begin
    logic [103:0] d0, d1, d2, top;
    logic [11:0]  c;
    rst      = 1'b1;
    mode_chk = 1'b0;
    in_vld   = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_dat   = '0;
    in_crc   = '0;
    res_rdy  = 1'b0;
    m_busy   = 1'b0;
    m_rem    = '0;
    m_cnt    = '0;
    m_mode   = 1'b0;
    top      = '0;
    top[103] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(res_vld), 32'd0);
    chk("rst_rdy", 32'(in_rdy), 32'd1);
    chk("rst_crc", 32'(res_crc), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    chk("rst_len", 32'(res_len_err), 32'd0);
    chk("rst_nwrd", 32'(res_nwrd), 32'd0);
    chk("rst_ev", 32'({ev_nosop, ev_abort}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single-word frame, generate mode
    word(1'b1, 1'b1, 1'b0, top, 12'h000);
    chk("w1_crc_const", 32'(res_crc), 32'h80F);
    get_result();

    // two-word check frames, good then bad expected CRC
    word(1'b1, 1'b0, 1'b1, '0, 12'h000);
    word(1'b0, 1'b1, 1'b1, top, 12'h80F);
    chk("chk_ok_const", 32'({res_err, res_crc}), 32'h080F);
    get_result();
    word(1'b1, 1'b0, 1'b1, '0, 12'h000);
    word(1'b0, 1'b1, 1'b1, top, 12'h80E);
    chk("chk_bad_const", 32'({res_err, res_crc}), 32'h180F);
    get_result();

    // back-pressure on the result while words keep arriving
    d0 = rnd();
    word(1'b1, 1'b1, 1'b0, d0, 12'h000);
    in_vld = 1'b1;
    in_sop = 1'b1;
    in_eop = 1'b1;
    in_dat = rnd();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rdy", 32'(in_rdy), 32'd0);
      chk("hold_vld", 32'(res_vld), 32'd1);
      chk("hold_crc", 32'(res_crc), 32'(sb[0].crc));
      chk("hold_nwrd", 32'(res_nwrd), 32'd1);
      @(negedge clk);
    end
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    get_result();

    // non-SOP word while idle is dropped
    word(1'b0, 1'b1, 1'b0, rnd(), 12'h000);
    chk("nosop_pulse", 32'(ev_nosop), 32'd1);
    chk("nosop_nores", 32'(res_vld), 32'd0);
    @(negedge clk);
    chk("nosop_end", 32'(ev_nosop), 32'd0);
    chk("nosop_nores2", 32'(res_vld), 32'd0);

    // SOP in BUSY aborts and restarts
    d0 = rnd();
    d1 = rnd();
    d2 = rnd();
    word(1'b1, 1'b0, 1'b0, d0, 12'h000);
    chk("abort_quiet", 32'(ev_abort), 32'd0);
    word(1'b1, 1'b0, 1'b0, d1, 12'h000);
    chk("abort_pulse", 32'(ev_abort), 32'd1);
    word(1'b0, 1'b1, 1'b0, d2, 12'h000);
    chk("abort_end", 32'(ev_abort), 32'd0);
    get_result();

    // check mode with a correct random CRC
    d0 = rnd();
    d1 = rnd();
    c  = crc_ref(crc_ref(12'h000, d0), d1);
    word(1'b1, 1'b0, 1'b1, d0, 12'h000);
    word(1'b0, 1'b1, 1'b1, d1, c);
    get_result();

    // three words: over the limit for MAX_WORDS = 2 only
    word(1'b1, 1'b0, 1'b0, rnd(), 12'h000);
    word(1'b0, 1'b0, 1'b0, rnd(), 12'h000);
    word(1'b0, 1'b1, 1'b0, rnd(), 12'h000);
    chk("len3_dut2", 32'({res_len_err2, res_nwrd2}), 32'h103);
    get_result();

    // seventeen words: over the default limit as well
    word(1'b1, 1'b0, 1'b0, rnd(), 12'h000);
    for (int i = 0; i < 15; i++)
      word(1'b0, 1'b0, 1'b0, rnd(), 12'h000);
    word(1'b0, 1'b1, 1'b0, rnd(), 12'h000);
    get_result();

    // reset mid-frame discards it
    word(1'b1, 1'b0, 1'b0, rnd(), 12'h000);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_vld", 32'(res_vld), 32'd0);
    chk("mrst_rdy", 32'(in_rdy), 32'd1);
    chk("mrst_nwrd", 32'(res_nwrd), 32'd0);
    rst    = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    word(1'b0, 1'b1, 1'b0, rnd(), 12'h000);
    chk("mrst_nosop", 32'(ev_nosop), 32'd1);
    chk("mrst_nores", 32'(res_vld), 32'd0);
    word(1'b1, 1'b1, 1'b0, top, 12'h000);
    chk("mrst_crc_const", 32'(res_crc), 32'h80F);
    get_result();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ippcrc_crc12_frmctl.md
IPPCRC_CRC12_FRMCTL -- requirements
Module: ippcrc_crc12_frmctl

Interface
REQ-001 SHALL have parameter CRC_INIT, default 12'h000: remainder seed loaded on each start-of-frame word.
REQ-002 SHALL have parameter CRC_XOROUT, default 12'h000: value XORed onto the final remainder.
REQ-003 SHALL have parameter MAX_WORDS, default 16 (range 1..255): maximum legal words per frame.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port mode_chk, input, 1: 0 = generate, 1 = check; sampled on the SOP word only.
REQ-007 SHALL have ports in_vld (input, 1) and in_rdy (output, 1): input word handshake.
REQ-008 SHALL have ports in_sop (input, 1) and in_eop (input, 1): frame delimiters, qualified by in_vld.
REQ-009 SHALL have port in_dat, input, 104: payload word, passed unmodified as di of one ippcrc_crc12_104b instance.
REQ-010 SHALL have port in_crc, input, 12: expected CRC, sampled with the EOP word in check mode.
REQ-011 SHALL have ports res_vld (output, 1) and res_rdy (input, 1): result handshake.
REQ-012 SHALL have port res_crc, output, 12: final CRC of the completed frame (remainder ^ CRC_XOROUT).
REQ-013 SHALL have port res_err, output, 1: check mode only; 1 when res_crc != in_crc; 0 in generate mode.
REQ-014 SHALL have port res_len_err, output, 1: frame word count exceeded MAX_WORDS.
REQ-015 SHALL have port res_nwrd, output, 8: accepted word count of the frame, saturating at 255.
REQ-016 SHALL have ports ev_nosop (output, 1) and ev_abort (output, 1): one-cycle event pulses.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and RESULT.
REQ-018 SHALL define word acceptance as in_vld & in_rdy, with in_rdy = 1 in IDLE and BUSY and 0 in RESULT (decoded from the registered state only).
REQ-019 SHALL, on an accepted SOP word, compute rem_nxt = core(ci = CRC_INIT, di = in_dat), clear the word count to 1, and latch mode_chk.
REQ-020 SHALL, on an accepted non-SOP word in BUSY, compute rem_nxt = core(ci = rem_q, di = in_dat) and increment the word count, saturating at 255.
REQ-021 SHALL have a latency of 1 cycle from an accepted EOP word to res_vld = 1, with res_crc/res_err/res_len_err/res_nwrd registered and state = RESULT.
REQ-022 SHALL hold all res_* outputs stable while res_vld & !res_rdy.
REQ-023 SHALL, on res_vld & res_rdy, drop res_vld on the next cycle and enter IDLE; in_rdy is 1 from that cycle.
REQ-024 SHALL treat a word with both SOP and EOP as a single-word frame: IDLE -> RESULT directly, res_nwrd = 1.
REQ-025 SHALL perform IDLE transitions: SOP without EOP -> BUSY; SOP with EOP -> RESULT; non-SOP word -> word dropped, ev_nosop pulses, stay in IDLE.
REQ-026 SHALL, on an SOP word in BUSY, discard the partial frame, pulse ev_abort, and restart per REQ-019 (or go to RESULT if EOP is also set).
REQ-027 SHALL set res_len_err = 1 when the final word count > MAX_WORDS; accumulation continues regardless.
REQ-028 SHALL keep rem_q unchanged and take no action in cycles without acceptance.
REQ-029 SHALL compute res_err = latched mode_chk & (res_crc != in_crc sampled on the EOP word).

Reset
REQ-030 SHALL, while rst = 1, force state = IDLE, rem_q = CRC_INIT, word count = 0, res_vld = 0, res_crc = 0, res_err = 0, res_len_err = 0, res_nwrd = 0, ev_nosop = 0, ev_abort = 0, in_rdy = 1 (after state settles).
REQ-031 SHALL, on rst asserted mid-frame or in RESULT, discard the frame and any pending result with no event pulse; the first post-reset word must carry SOP.

Verification
REQ-032 SHALL cover: defaults, single word SOP+EOP, in_dat = 104'h0 with bit 103 set, generate mode -> res_vld 1 cycle later, res_crc = 12'h80F, res_nwrd = 1, res_err = 0.
REQ-033 SHALL cover: two-word frame, word0 = 0 (SOP), word1 bit 103 set (EOP), check mode with in_crc = 12'h80F -> res_crc = 12'h80F, res_err = 0, res_nwrd = 2; repeated with in_crc = 12'h80E -> res_err = 1.
REQ-034 SHALL cover: result held with res_rdy = 0 for 5 cycles while in_vld = 1 -> in_rdy = 0 and outputs stable throughout; on res_rdy = 1, IDLE and in_rdy = 1 the next cycle.
REQ-035 SHALL cover: non-SOP word in IDLE -> ev_nosop 1-cycle pulse, no result; SOP in BUSY -> ev_abort pulse and restarted frame yields the correct CRC.
REQ-036 SHALL cover: MAX_WORDS = 2 with a 3-word frame -> res_len_err = 1, res_nwrd = 3.
REQ-037 SHALL cover: rst asserted in BUSY after 1 word -> res_vld stays 0, and the next SOP+EOP frame gives the same result as REQ-032.
